// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker: a lone requester always wins, and a tie goes to
// the port that did not win last. After reset the data port wins the first tie.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_if,
    input  logic req_d,
    input  logic advance,
    output logic grant_valid,
    output logic grant_port
);

    logic last_port;

    always_comb begin
        grant_valid = req_if | req_d;
        grant_port  = PORT_IF;
        if (req_if && req_d) begin
            grant_port = ~last_port;
        end else if (req_d) begin
            grant_port = PORT_D;
        end
    end

    // Remembering the fetch port as the last winner makes data win the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_port <= PORT_IF;
        end else if (advance && grant_valid) begin
            last_port <= grant_port;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory using a
// four-state FSM (IDLE/READ/WRITE/DONE) with a timed read wait and write hold.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [MEM_AW-1:0] if_addr,
    output logic [MEM_DW-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [MEM_AW-1:0] d_addr,
    input  logic [MEM_DW-1:0] d_wdata,
    output logic [MEM_DW-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic              busy
);

    // Handshake: a port raises req with stable operands and holds both until it
    // sees its one-cycle ack; req still high in the following IDLE cycle is a
    // fresh request. Requests seen while busy simply wait for IDLE.

    localparam logic [3:0] READ_LAST  = 4'(READ_WAIT - 1);
    localparam logic [3:0] WRITE_LAST = 4'(WRITE_HOLD - 1);

    arb_state_t state, state_next;
    logic [3:0] cnt;
    logic       sel_port;
    logic       grant_valid;
    logic       grant_port;
    logic       take_grant;

    mem_arb_rr u_rr (
        .clk        (clk),
        .reset      (reset),
        .req_if     (if_req),
        .req_d      (d_req),
        .advance    (take_grant),
        .grant_valid(grant_valid),
        .grant_port (grant_port)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    take_grant = 1'b1;
                    state_next = (grant_port == PORT_D && d_we) ? WRITE : READ;
                end
            end
            READ: begin
                mem_read = 1'b1;
                if (cnt == READ_LAST) state_next = DONE;
            end
            WRITE: begin
                mem_write = 1'b1;
                if (cnt == WRITE_LAST) state_next = DONE;
            end
            DONE: begin
                if_ack     = (sel_port == PORT_IF);
                d_ack      = (sel_port == PORT_D);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            sel_port  <= PORT_D;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (state_next != state) begin
                cnt <= '0;
            end else if (state == READ || state == WRITE) begin
                cnt <= cnt + 4'd1;
            end

            // Fetch grants carry no write data, so mem_wdata keeps its last value.
            if (take_grant) begin
                sel_port <= grant_port;
                if (grant_port == PORT_D) begin
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_addr <= if_addr;
                end
            end

            if (state == READ && cnt == READ_LAST) begin
                if (sel_port == PORT_IF) begin
                    if_rdata <= mem_rdata;
                end else begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory model, transaction driver, expected-queue
// scoreboard for the contended stream, and a one-line report.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] ram [256];
    int          wr_run = 0;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total_cnt = 0;
    logic [32:0] exp_q [$];

    mem_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ack   (if_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    // clock / memory model
    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];

    // The memory commits a write only once the strobe has been held 4 cycles.
    always @(posedge clk) begin
        if (mem_write) begin
            if (wr_run == 3) ram[mem_addr] <= mem_wdata;
            wr_run <= wr_run + 1;
        end else begin
            wr_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver: one transaction, returns latency from the grant cycle to the ack cycle
    task automatic txn(input logic port, input logic we, input logic [7:0] addr,
                       input logic [31:0] wdata, output int lat, output int rd,
                       output int wr, output int bad, output logic got);
        lat = 0; rd = 0; wr = 0; bad = 0; got = 1'b0;
        if (port == PORT_D) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (mem_read) begin
                rd++;
                if (mem_addr !== addr) bad++;
            end
            if (mem_write) begin
                wr++;
                if (mem_addr !== addr || mem_wdata !== wdata) bad++;
            end
            if (mem_read && mem_write) bad++;
            if (if_ack && d_ack) bad++;
            if ((port == PORT_D) ? d_ack : if_ack) got = 1'b1;
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", 32'(if_ack | d_ack), 32'd0);
    endtask

    initial begin
        int          lat, rd, wr, bad;
        logic        got;
        int          acks, simul, idle_run, max_idle, stray;
        logic [32:0] e;

        for (int i = 0; i < 256; i++) ram[i] <= 32'(10 * i + 1);
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {27'd0, mem_read, mem_write, if_ack, d_ack, busy}, 32'd0);
        check("reset_mem_addr", 32'(mem_addr), 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        check("reset_rdata", if_rdata | d_rdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // data read of address 5
        txn(PORT_D, 1'b0, 8'd5, 32'd0, lat, rd, wr, bad, got);
        check("rd5_ack", 32'(got), 32'd1);
        check("rd5_latency", 32'(lat), 32'd2);
        check("rd5_read_cycles", 32'(rd), 32'd1);
        check("rd5_write_cycles", 32'(wr), 32'd0);
        check("rd5_bad", 32'(bad), 32'd0);
        check("rd5_d_rdata", d_rdata, 32'd51);
        check("rd5_if_rdata", if_rdata, 32'd0);

        // data write of 0xDEADBEEF to address 7
        txn(PORT_D, 1'b1, 8'd7, 32'hDEAD_BEEF, lat, rd, wr, bad, got);
        check("wr7_ack", 32'(got), 32'd1);
        check("wr7_latency", 32'(lat), 32'd5);
        check("wr7_write_cycles", 32'(wr), 32'd4);
        check("wr7_read_cycles", 32'(rd), 32'd0);
        check("wr7_bad", 32'(bad), 32'd0);
        check("wr7_d_rdata_kept", d_rdata, 32'd51);

        // fetch read of address 7 sees the written word
        txn(PORT_IF, 1'b0, 8'd7, 32'd0, lat, rd, wr, bad, got);
        check("if7_ack", 32'(got), 32'd1);
        check("if7_latency", 32'(lat), 32'd2);
        check("if7_bad", 32'(bad), 32'd0);
        check("if7_if_rdata", if_rdata, 32'hDEAD_BEEF);
        check("if7_d_rdata_kept", d_rdata, 32'd51);

        // reset during the second WRITE cycle to address 9
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd9; d_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        check("abort_wr_c1", 32'(mem_write), 32'd1);
        @(posedge clk); #1;
        check("abort_wr_c2", 32'(mem_write), 32'd1);
        reset = 1'b1;
        d_req = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_write", 32'(mem_write), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_d_ack", 32'(d_ack), 32'd0);
        reset = 1'b0;
        stray = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (d_ack || if_ack || busy) stray++;
        end
        check("abort_no_ack", 32'(stray), 32'd0);
        txn(PORT_D, 1'b0, 8'd9, 32'd0, lat, rd, wr, bad, got);
        check("rd9_ack", 32'(got), 32'd1);
        check("rd9_d_rdata", d_rdata, 32'd91);

        // both ports requesting continuously from a fresh reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) exp_q.push_back({PORT_D, 32'd21});
            else            exp_q.push_back({PORT_IF, 32'd11});
        end
        if_req = 1'b1; if_addr = 8'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'd2;
        acks = 0; simul = 0; idle_run = 0; max_idle = 0;
        for (int c = 0; c < 200 && acks < 10; c++) begin
            @(posedge clk); #1;
            if (if_ack && d_ack) simul++;
            if (!busy) begin
                idle_run++;
                if (idle_run > max_idle) max_idle = idle_run;
            end else begin
                idle_run = 0;
            end
            if ((if_ack || d_ack) && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("tie_port_%0d", acks), 32'(d_ack), 32'(e[32]));
                check($sformatf("tie_rdata_%0d", acks), d_ack ? d_rdata : if_rdata, e[31:0]);
                acks++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        check("stream_acks", 32'(acks), 32'd10);
        check("stream_simul_ack", 32'(simul), 32'd0);
        check("stream_idle_gap", 32'(max_idle <= 1), 32'd1);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
